// File: rtl/dcache_ctrl_if.sv
// Backing-memory bus between the data cache and data memory.
// The cache drives the request side; memory answers with read data and a one-cycle ack.
interface dcache_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read hits return in the same cycle; misses and writes stall until the memory ack.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic             stall_o,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o,
  dcache_ctrl_if.master    mem
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic        req_q, we_q, wr_hit_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  logic [31:0]      addr_al;
  logic [IDX-1:0]   idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic             hit, rd_req;

  logic launch_rd, launch_wr, fill, wr_upd, done, hit_inc, miss_inc;

  assign addr_al = addr_i & 32'hFFFF_FFFC;
  assign idx     = addr_al[IDX+1:2];
  assign tag     = addr_al[31:IDX+2];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_req  = MemRead_i && !MemWrite_i;

  // Completion-time line updates use the latched request address
  assign fidx = addr_q[IDX+1:2];
  assign ftag = addr_q[31:IDX+2];

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    data_o    = 32'h0;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    fill      = 1'b0;
    wr_upd    = 1'b0;
    done      = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemWrite_i) begin
          stall_o   = 1'b1;
          launch_wr = 1'b1;
          state_d   = WR_THRU;
        end else if (rd_req) begin
          if (hit) begin
            data_o  = data_q[idx];
            hit_inc = 1'b1;
          end else begin
            stall_o   = 1'b1;
            launch_rd = 1'b1;
            state_d   = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall_o = 1'b1;
        if (mem.mem_ack_i) begin
          stall_o  = 1'b0;
          data_o   = mem.mem_rdata_i;
          fill     = 1'b1;
          done     = 1'b1;
          miss_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      WR_THRU: begin
        stall_o = 1'b1;
        if (mem.mem_ack_i) begin
          stall_o  = 1'b0;
          done     = 1'b1;
          wr_upd   = wr_hit_q;
          hit_inc  = wr_hit_q;
          miss_inc = !wr_hit_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wr_hit_q   <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (launch_rd || launch_wr) begin
        req_q  <= 1'b1;
        we_q   <= launch_wr;
        addr_q <= addr_al;
      end else if (done) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
      end
      if (launch_wr) begin
        wdata_q  <= data_i;
        wr_hit_q <= hit;
      end
      if (fill)     valid_q[fidx] <= 1'b1;
      if (hit_inc)  hit_cnt_q     <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q    <= miss_cnt_q + 32'd1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[fidx]  <= ftag;
      data_q[fidx] <= mem.mem_rdata_i;
    end else if (wr_upd) begin
      data_q[fidx] <= wdata_q;
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses push expected load data,
// a negedge monitor pops and compares on every completed access.
module tb_dcache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic [31:0] data_o, hit_cnt, miss_cnt;
  logic        stall;

  always #5 clk_i = ~clk_i;

  dcache_ctrl_if mbus ();

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_n),
    .MemRead_i  (MemRead),
    .MemWrite_i (MemWrite),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (data_o),
    .stall_o    (stall),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .mem        (mbus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every access that completes (request present, no stall) consumes one entry
  always @(negedge clk_i) begin
    if (rst_n && (MemRead || MemWrite) && !stall) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_underflow: completion seen with no expected entry");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) chk("rd_data", data_o, mon_e.data);
      end
    end
  end

  // Memory model: holds the request for mem_lat cycles, then a one-cycle ack
  int          mem_lat = 1;
  logic [31:0] mem_rd_val = 32'h0;
  int          mcnt = 0;

  initial begin
    mbus.mem_ack_i   = 1'b0;
    mbus.mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_n) begin
        mcnt           = 0;
        mbus.mem_ack_i = 1'b0;
      end else if (mbus.mem_ack_i) begin
        mbus.mem_ack_i = 1'b0;
        mcnt           = 0;
      end else if (mbus.mem_req_o) begin
        mcnt++;
        if (mcnt > mem_lat) begin
          mbus.mem_ack_i   = 1'b1;
          mbus.mem_rdata_i = mem_rd_val;
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic [31:0] rdv,
                        input int exp_stall, input logic [31:0] exp_rd, input string name);
    int   n    = 0;
    bit   done = 1'b0;
    exp_t e;
    mem_lat    = lat;
    mem_rd_val = rdv;
    e.is_rd    = rd && !wr;
    e.data     = exp_rd;
    sb.push_back(e);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk_i);
      if (stall) begin
        n++;
        if (n > 1) begin
          chk({name, "_req"},  32'(mbus.mem_req_o), 32'd1);
          chk({name, "_we"},   32'(mbus.mem_we_o), 32'(wr));
          chk({name, "_addr"}, mbus.mem_addr_o, {a[31:2], 2'b00});
          if (wr) chk({name, "_wdata"}, mbus.mem_wdata_o, wd);
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: still stalled after 64 cycles, completion required", name);
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk_i);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk({name, "_req_after"}, 32'(mbus.mem_req_o), 32'd0);
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] h, input logic [31:0] m);
    chk({name, "_hit_cnt"},  hit_cnt,  h);
    chk({name, "_miss_cnt"}, miss_cnt, m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_data",   data_o, 32'h0);
    chk("rst_req",    32'(mbus.mem_req_o), 32'd0);
    chk("rst_we",     32'(mbus.mem_we_o), 32'd0);
    chk("rst_addr",   mbus.mem_addr_o, 32'h0);
    chk("rst_wdata",  mbus.mem_wdata_o, 32'h0);
    chk_cnt("rst", 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, 32'hDEADBEEF, "rd_miss_100");
    chk_cnt("rd_miss_100", 32'd0, 32'd1);
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h0, 0, 32'hDEADBEEF, "rd_hit_100");
    chk_cnt("rd_hit_100", 32'd1, 32'd1);
    access(1'b1, 1'b0, 32'h140, 32'h0, 1, 32'h11112222, 2, 32'h11112222, "rd_miss_140");
    access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 3, 32'hDEADBEEF, "rd_conflict_100");
    chk_cnt("conflict", 32'd1, 32'd3);

    access(1'b0, 1'b1, 32'h100, 32'h55AA, 2, 32'h0, 3, 32'h0, "wr_hit_100");
    chk_cnt("wr_hit_100", 32'd2, 32'd3);
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h0, 0, 32'h000055AA, "rd_after_wr");
    chk_cnt("rd_after_wr", 32'd3, 32'd3);

    access(1'b0, 1'b1, 32'h200, 32'h1234, 1, 32'h0, 2, 32'h0, "wr_miss_200");
    chk_cnt("wr_miss_200", 32'd3, 32'd4);
    access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'hCAFEF00D, 2, 32'hCAFEF00D, "rd_miss_200");
    chk_cnt("rd_miss_200", 32'd3, 32'd5);

    // Abandon a read miss with reset before memory acks
    mem_lat  = 10;
    MemRead  = 1'b1;
    addr     = 32'h140;
    repeat (3) @(posedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mbus.mem_req_o), 32'd0);
    chk("midrst_we",  32'(mbus.mem_we_o), 32'd0);
    chk_cnt("midrst", 32'd0, 32'd0);
    MemRead = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    access(1'b1, 1'b0, 32'h140, 32'h0, 1, 32'h0BADF00D, 2, 32'h0BADF00D, "rd_after_rst");
    chk_cnt("rd_after_rst", 32'd0, 32'd1);
    access(1'b1, 1'b0, 32'h140, 32'h0, 1, 32'h0, 0, 32'h0BADF00D, "rd_hit_after_rst");
    chk_cnt("rd_hit_after_rst", 32'd1, 32'd1);

    access(1'b1, 1'b1, 32'h300, 32'hABCD, 1, 32'h0, 2, 32'h0, "rdwr_300");
    chk_cnt("rdwr_300", 32'd1, 32'd2);
    access(1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h00000077, 2, 32'h00000077, "rd_300_noalloc");
    chk_cnt("rd_300_noalloc", 32'd1, 32'd3);

    @(negedge clk_i);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_data",  data_o, 32'h0);
    chk("sb_empty",   32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
